ram32x3_ctrl: RTL and testbench
===============================

// Module: ram32x3_ctrl
// PURPOSE
//   Access controller for the 32x3 dual-port RAM (ram32x3port2), instantiated inside this block.
//   Two requesters (A, B) share the RAM. Write and read ports are arbitrated independently.
//   After reset, or on a clr pulse, the RAM is cleared to INIT_VAL before any access is granted.
//   Sits between lab-level control logic (switch/FSM requesters) and the RAM macro.
// PARAMETERS
//   RD_LAT    2       clock->q read latency of the RAM macro, in cycles (address reg + output reg)
//   INIT_VAL  3'b000  value written to every word during initialisation
//   (ADDR_W=5, DATA_W=3, DEPTH=32 are fixed by the macro; see package)
// PORTS
//   clock      in   1  single clock; everything is posedge
//   reset      in   1  synchronous, active-low
//   clr        in   1  pulse: re-run initialisation (ignored while busy)
//   a_req      in   1  requester A wants an access; held until a_gnt
//   a_we       in   1  1 = write, 0 = read (valid with a_req)
//   a_addr     in   5  word address
//   a_wdata    in   3  write data
//   a_gnt      out  1  combinational grant; access is taken this cycle
//   b_req/b_we/b_addr/b_wdata/b_gnt   same as A, for requester B
//   rd_valid   out  1  rd_data/rd_id valid this cycle
//   rd_data    out  3  read result
//   rd_id      out  1  0 = result for A, 1 = result for B
//   busy       out  1  initialisation in progress; no grants
// BEHAVIOUR
//   Reset (reset==0 at posedge):
//     - gnts=0, rd_valid=0, rd_data=0, rd_id=0, busy=1.
//     - Both arbitration priority bits = A.
//     - The read pipeline is flushed; in-flight reads are dropped.
//     - State goes to S_INIT, init counter = 0.
//   S_INIT:
//     - One write per cycle, INIT_VAL to addresses 0..31 in order (exactly 32 cycles). busy=1, gnts=0.
//     - After the write to 31: next cycle S_SERVE, busy=0.
//     - Requests are held off, not lost.
//   S_SERVE, write port:
//     - Candidates are req & we.
//     - One candidate: grant it.
//     - Both: grant the side named by wr_pri, then toggle wr_pri.
//     - The loser keeps req high and wins the next conflict.
//   S_SERVE, read port:
//     - Same scheme on req & ~we with rd_pri.
//     - A read and a write from different requesters are granted in the same cycle.
//   Each requester gets at most one grant per cycle.
//   Read result: rd_valid, rd_data and rd_id appear exactly RD_LAT cycles after the grant cycle.
//   Back-to-back reads give one result per cycle, in order.
//   Read/write collision (same cycle, same address):
//     - The controller bypasses and returns the new write data, never the old word.
//     - The bypass flag and data are pipelined RD_LAT deep alongside rd_id.
//   A write to address X in cycle N is visible to a read of X granted in cycle N+1 or later.
//   clr in S_SERVE:
//     - Enter S_INIT next cycle.
//     - Reads already granted still complete with their RAM value.
//     - No new grants.
//   Reset mid-initialisation restarts from address 0.
// STRUCTURE
//   Package ram_ctrl_pkg:
//     - ADDR_W=5, DATA_W=3, DEPTH=32.
//     - typedef enum logic {S_INIT, S_SERVE} state_t.
//     - typedef logic req_id_t (0=A, 1=B).
//   Sub-module rr_arb2 (2-way round-robin: req[1:0] -> gnt[1:0], owns its pri bit, reset-low):
//     - Instantiated once for the write port, once for the read port.
//   Top level holds: RAM mux (init vs granted write), state/counter, and the RD_LAT-deep
//   {valid, id, bypass, bypass_data} shift pipeline.
// TESTING
//   1. reset=0 for 2 cycles, then 1 -> busy high exactly 32 cycles, no gnt; then A reads 0..31 -> all 3'b000.
//   2. A writes addr 5 = 3'b101; next cycle B reads 5 -> b_gnt same cycle; 2 cycles later
//      rd_valid=1, rd_data=101, rd_id=1.
//   3. A and B both write (addr 1=3'b001 and 2=3'b010) for 2 cycles -> grant A then B;
//      readback gives addr1=001, addr2=010.
//   4. A writes addr 9=3'b110 while B reads 9 in the same cycle -> both granted;
//      rd_data=110, rd_id=1 after RD_LAT.
//   5. A read granted, reset=0 on the next cycle -> rd_valid never asserts for it; busy=1 for 32 cycles after release.
//   6. Fill addr 3=3'b111, pulse clr -> busy 32 cycles; read 3 -> INIT_VAL; a clr pulse during busy has no effect.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared widths, FSM state encoding and read-pipeline entry type for the
// 32x3 RAM access controller.
package ram_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 32;

    typedef enum logic {S_INIT, S_SERVE} state_t;

    // 0 = requester A, 1 = requester B
    typedef logic req_id_t;

    typedef struct packed {
        logic              valid;
        req_id_t           id;
        logic              byp;
        logic [DATA_W-1:0] bdata;
    } rd_pipe_t;

endpackage

// File: rtl/ram32x3_ctrl_arb.sv
// Two-way round-robin arbiter (module rr_arb2): one grant per cycle, the
// priority bit flips only when both sides compete, so the loser wins next time.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic pri_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = pri_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pri_q <= 1'b0;
        end else if (en_i && (req_i == 2'b11)) begin
            pri_q <= ~pri_q;
        end
    end

endmodule

// File: rtl/ram32x3port2.sv
// Behavioural model of the 32x3 dual-port RAM macro: one write port, one read
// port with registered address and registered output (2-cycle read latency).
module ram32x3port2
    import ram_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        addr_q <= raddr_i;
        q_q    <= mem_q[addr_q];
    end

    assign q_o = q_q;

endmodule

// File: rtl/ram32x3_ctrl.sv
// Access controller for the 32x3 RAM: clears the RAM after reset/clr, then
// arbitrates A/B independently on the write and read ports.
module ram32x3_ctrl
    import ram_ctrl_pkg::*;
#(
    // The RAM macro latency is fixed at 2; RD_LAT must match it.
    parameter int                RD_LAT   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_id,
    output logic              busy
);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    logic              serve;
    logic [1:0]        wr_req, rd_req, wr_gnt, rd_gnt;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_q;
    logic              rd_fire, wr_fire, byp;

    rd_pipe_t          pipe_q [RD_LAT];

    // Grants are suppressed during reset, initialisation and the clr cycle itself.
    assign serve  = reset && (state_q == S_SERVE) && !clr;
    assign wr_req = {b_req & b_we,  a_req & a_we};
    assign rd_req = {b_req & ~b_we, a_req & ~a_we};

    rr_arb2 u_wr_arb (
        .clk_i (clock),
        .rst_ni(reset),
        .en_i  (serve),
        .req_i (wr_req),
        .gnt_o (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk_i (clock),
        .rst_ni(reset),
        .en_i  (serve),
        .req_i (rd_req),
        .gnt_o (rd_gnt)
    );

    assign a_gnt = wr_gnt[0] | rd_gnt[0];
    assign b_gnt = wr_gnt[1] | rd_gnt[1];

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = INIT_VAL;
        if (state_q == S_INIT) begin
            ram_we = 1'b1;
        end else if (wr_gnt[1]) begin
            ram_we    = 1'b1;
            ram_waddr = b_addr;
            ram_wdata = b_wdata;
        end else if (wr_gnt[0]) begin
            ram_we    = 1'b1;
            ram_waddr = a_addr;
            ram_wdata = a_wdata;
        end
    end

    assign rd_fire   = |rd_gnt;
    assign wr_fire   = |wr_gnt;
    assign ram_raddr = rd_gnt[1] ? b_addr : a_addr;
    // Same-cycle write to the read address: return the fresh write data.
    assign byp       = rd_fire && wr_fire && (ram_waddr == ram_raddr);

    ram32x3port2 u_ram (
        .clk_i  (clock),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .raddr_i(ram_raddr),
        .q_o    (ram_q)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: rd_fire, id: rd_gnt[1], byp: byp, bdata: ram_wdata};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rd_valid = pipe_q[RD_LAT-1].valid;
    assign rd_id    = pipe_q[RD_LAT-1].id;
    assign rd_data  = !pipe_q[RD_LAT-1].valid ? '0 :
                      (pipe_q[RD_LAT-1].byp ? pipe_q[RD_LAT-1].bdata : ram_q);

    // clr is only honoured in S_SERVE; a clr during initialisation is ignored.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_SERVE;
                        busy_q  <= 1'b0;
                    end
                end
                S_SERVE: begin
                    if (clr) begin
                        state_q <= S_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_ram32x3_ctrl.sv
// Directed self-checking bench for ram32x3_ctrl: init, writes, reads,
// arbitration, bypass, reset flush and clr behaviour.
module tb_ram32x3_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [4:0] a_addr = '0;
    logic [2:0] a_wdata = '0;
    logic       a_gnt;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [4:0] b_addr = '0;
    logic [2:0] b_wdata = '0;
    logic       b_gnt;
    logic       rd_valid;
    logic [2:0] rd_data;
    logic       rd_id;
    logic       busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    ram32x3_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .a_req   (a_req),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_gnt   (a_gnt),
        .b_req   (b_req),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_gnt   (b_gnt),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_id   (rd_id),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles from the current negedge; optionally pulses clr mid-init.
    task automatic applyStimulus(input int clrAt, output int cyc, output int gntSeen, output int vldSeen);
        cyc = 0; gntSeen = 0; vldSeen = 0;
        for (int k = 0; k < 64; k++) begin
            if (busy !== 1'b1) break;
            cyc++;
            if (a_gnt || b_gnt) gntSeen++;
            if (rd_valid) vldSeen++;
            clr = (k == clrAt);
            step();
        end
        clr = 1'b0;
    endtask

    task automatic doRead(input bit sideB, input logic [4:0] addr, input logic [2:0] expData, input string tag);
        if (sideB) begin b_req = 1'b1; b_we = 1'b0; b_addr = addr; end
        else       begin a_req = 1'b1; a_we = 1'b0; a_addr = addr; end
        #1;
        checkOutput({tag, "_gnt"}, sideB ? b_gnt : a_gnt, 1);
        step();
        a_req = 1'b0; b_req = 1'b0;
        step();
        checkOutput({tag, "_vld"}, rd_valid, 1);
        checkOutput({tag, "_data"}, rd_data, expData);
        checkOutput({tag, "_id"}, rd_id, sideB);
    endtask

    task automatic doWrite(input logic [4:0] addr, input logic [2:0] data, input string tag);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
        #1;
        checkOutput({tag, "_gnt"}, a_gnt, 1);
        step();
        a_req = 1'b0;
    endtask

    initial begin
        int cyc, gntSeen, vldSeen, bad;

        // 1. reset state, init length, held-off request, full readback
        @(negedge clock);
        step();
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_gnt", {a_gnt, b_gnt}, 0);
        checkOutput("rst_vld", rd_valid, 0);
        checkOutput("rst_data", rd_data, 0);
        checkOutput("rst_id", rd_id, 0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd0;
        reset = 1'b1;
        applyStimulus(-1, cyc, gntSeen, vldSeen);
        checkOutput("init_len", cyc, 32);
        checkOutput("init_nogrant", gntSeen, 0);
        bad = 0;
        for (int i = 0; i < 34; i++) begin
            if (i >= 2 && !(rd_valid === 1'b1 && rd_data === 3'b000 && rd_id === 1'b0)) bad++;
            if (i < 32) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 5'(i);
                #1;
                if (a_gnt !== 1'b1) bad++;
            end else begin
                a_req = 1'b0;
            end
            step();
        end
        checkOutput("init_readback_errs", bad, 0);
        checkOutput("rd_idle", rd_valid, 0);

        // 2. write then read from B on the next cycle
        doWrite(5'd5, 3'b101, "t2_wr");
        doRead(1'b1, 5'd5, 3'b101, "t2_rd");

        // 3. write conflict: A first, then B
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd1; a_wdata = 3'b001;
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd2; b_wdata = 3'b010;
        #1;
        checkOutput("t3_c1_gnt", {b_gnt, a_gnt}, 2'b01);
        step();
        #1;
        checkOutput("t3_c2_gnt", {b_gnt, a_gnt}, 2'b10);
        step();
        a_req = 1'b0; b_req = 1'b0;
        doRead(1'b0, 5'd1, 3'b001, "t3_rd1");
        doRead(1'b0, 5'd2, 3'b010, "t3_rd2");

        // read conflict: A then B, results back to back in order
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
        #1;
        checkOutput("rc_c1_gnt", {b_gnt, a_gnt}, 2'b01);
        step();
        a_req = 1'b0;
        #1;
        checkOutput("rc_c2_gnt", {b_gnt, a_gnt}, 2'b10);
        step();
        b_req = 1'b0;
        checkOutput("rc_r1", {rd_valid, rd_id, rd_data}, {1'b1, 1'b0, 3'b001});
        step();
        checkOutput("rc_r2", {rd_valid, rd_id, rd_data}, {1'b1, 1'b1, 3'b010});

        // 4. same-cycle write/read collision returns new data
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd9; a_wdata = 3'b110;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd9;
        #1;
        checkOutput("t4_gnt", {b_gnt, a_gnt}, 2'b11);
        step();
        a_req = 1'b0; b_req = 1'b0;
        step();
        checkOutput("t4_res", {rd_valid, rd_id, rd_data}, {1'b1, 1'b1, 3'b110});

        // 5. reset right after a read grant flushes it
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
        #1;
        checkOutput("t5_gnt", a_gnt, 1);
        step();
        a_req = 1'b0; reset = 1'b0;
        step();
        checkOutput("t5_flushed", rd_valid, 0);
        reset = 1'b1;
        applyStimulus(-1, cyc, gntSeen, vldSeen);
        checkOutput("t5_init_len", cyc, 32);
        checkOutput("t5_no_vld", vldSeen, 0);
        doRead(1'b0, 5'd5, 3'b000, "t5_cleared");

        // 6. clr: in-flight read completes, no new grants, clr during busy ignored
        doWrite(5'd3, 3'b111, "t6_wr");
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd3;
        #1;
        checkOutput("t6_rd_gnt", a_gnt, 1);
        step();
        a_req = 1'b0; clr = 1'b1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd0;
        #1;
        checkOutput("t6_clr_nogrant", b_gnt, 0);
        step();
        clr = 1'b0; b_req = 1'b0;
        checkOutput("t6_inflight", {rd_valid, rd_id, rd_data}, {1'b1, 1'b0, 3'b111});
        applyStimulus(10, cyc, gntSeen, vldSeen);
        checkOutput("t6_init_len", cyc, 32);
        doRead(1'b0, 5'd3, 3'b000, "t6_cleared");

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
